// File: rtl/sift_pkg.sv
// Shared constants, FSM encoding and window-slot helper for the 3x3 pixel
// window generator and its line buffers.
package sift_pkg;

  localparam int COLS_DEF  = 640;
  localparam int ROWS_DEF  = 480;
  localparam int PIX_W_DEF = 8;
  localparam int IN_W      = 16;
  localparam int ROW_W     = 9;
  localparam int COL_W     = 10;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slot index of window pixel (row i, column j) inside the flat window bus.
  function automatic int win_slot(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in / window stream out bundle of the 3x3 window generator.
interface pixel_window_3x3_if
  import sift_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);

  logic                 in_valid;
  logic [IN_W-1:0]      in_data;
  logic                 out_valid;
  logic [9*PIX_W-1:0]   out_win;
  logic [ROW_W-1:0]     out_row;
  logic [COL_W-1:0]     out_col;
  logic                 frame_done;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_win, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_win, out_row, out_col, frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// One image row of pixel storage: combinational read of the addressed entry,
// write on the clock edge, so a same-cycle read returns the old contents.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Store the accepted pixel; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_window_3x3.sv
// Raster-order pixel stream to 3x3 interior windows, one window per accepted
// pixel whose row and column are both at least 2.
module pixel_window_3x3
  import sift_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  pixel_window_3x3_if.slave bus
);

  localparam int               COL_AW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  state_e             state_r;
  logic               out_valid_r;
  logic               frame_done_r;
  logic [9*PIX_W-1:0] out_win_r;
  logic [ROW_W-1:0]   out_row_r;
  logic [COL_W-1:0]   out_col_r;

  logic [PIX_W-1:0]   win_r     [3][3];
  logic [PIX_W-1:0]   win_nxt_s [3][3];
  logic [9*PIX_W-1:0] win_flat_s;

  logic [PIX_W-1:0]   pix_s;
  logic [PIX_W-1:0]   lb1_rd_s;
  logic [PIX_W-1:0]   lb2_rd_s;
  logic               last_col_s;
  logic               last_row_s;
  logic               emit_s;
  logic               unused_hi_s;

  assign pix_s       = bus.in_data[PIX_W-1:0];
  assign unused_hi_s = ^bus.in_data[IN_W-1:PIX_W];
  assign last_col_s  = (col_r == COL_LAST);
  assign last_row_s  = (row_r == ROW_LAST);
  // RUN implies row >= 2, so only the column still has to clear the border.
  assign emit_s      = bus.in_valid && (state_r == ST_RUN) && (col_r >= 10'd2);

  // lb1 holds row r-1; lb2 holds row r-2 and is refilled from lb1's old word.
  line_buffer #(.DEPTH(COLS), .WIDTH(PIX_W), .AW(COL_AW)) u_lb1 (
    .clk     (clk),
    .we      (bus.in_valid),
    .addr    (col_r[COL_AW-1:0]),
    .wr_data (pix_s),
    .rd_data (lb1_rd_s)
  );

  line_buffer #(.DEPTH(COLS), .WIDTH(PIX_W), .AW(COL_AW)) u_lb2 (
    .clk     (clk),
    .we      (bus.in_valid),
    .addr    (col_r[COL_AW-1:0]),
    .wr_data (lb1_rd_s),
    .rd_data (lb2_rd_s)
  );

  // Window after a left shift with the new column {row r-2, row r-1, row r}.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_nxt_s[i][0] = win_r[i][1];
      win_nxt_s[i][1] = win_r[i][2];
    end
    win_nxt_s[0][2] = lb2_rd_s;
    win_nxt_s[1][2] = lb1_rd_s;
    win_nxt_s[2][2] = pix_s;
  end

  // Flatten the shifted window into the output slice order.
  always_comb begin
    win_flat_s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_flat_s[PIX_W*win_slot(i, j) +: PIX_W] = win_nxt_s[i][j];
      end
    end
  end

  // Raster position, frame FSM and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r        <= '0;
      row_r        <= '0;
      state_r      <= ST_FILL;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      out_win_r    <= '0;
      out_row_r    <= '0;
      out_col_r    <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else begin
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if (bus.in_valid) begin
        win_r <= win_nxt_s;
        if (last_col_s) begin
          col_r <= '0;
          row_r <= last_row_s ? 9'd0 : row_r + 9'd1;
        end else begin
          col_r <= col_r + 10'd1;
        end
        if (emit_s) begin
          out_valid_r <= 1'b1;
          out_win_r   <= win_flat_s;
          out_row_r   <= row_r - 9'd1;
          out_col_r   <= col_r - 10'd1;
        end
      end
      case (state_r)
        ST_FILL: begin
          if (bus.in_valid && last_col_s && (row_r == 9'd1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.in_valid && last_col_s && last_row_s) begin
            state_r      <= ST_DONE;
            frame_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_FILL;
        end
        default: begin
          state_r <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.out_win    = out_win_r;
  assign bus.out_row    = out_row_r;
  assign bus.out_col    = out_col_r;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Self-checking bench for pixel_window_3x3 on an 8x6 image: frame-level model
// checked every cycle plus hand-computed window literals.
module tb_pixel_window_3x3;
  import sift_pkg::*;

  localparam int COLS  = 8;
  localparam int ROWS  = 6;
  localparam int PIX_W = 8;
  localparam int NPIX  = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pixel_window_3x3_if #(.PIX_W(PIX_W)) bus ();

  pixel_window_3x3 #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model: the current frame as a 2-D image, indexed by accepted-beat count.
  logic [7:0]  img_m [ROWS][COLS];
  int          k_m = 0;
  logic        exp_valid = 1'b0;
  logic        exp_fd = 1'b0;
  logic [71:0] exp_win = '0;
  logic [8:0]  exp_row = '0;
  logic [9:0]  exp_col = '0;

  logic [71:0] cap_win [$];
  int          cap_row [$];
  int          cap_col [$];
  bit          cap_fd  [$];
  logic [71:0] ref_win [$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Single compare process: every negedge the DUT must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 72'(bus.out_valid), 72'(exp_valid));
      chk("frame_done", 72'(bus.frame_done), 72'(exp_fd));
      chk("out_win", bus.out_win, exp_win);
      chk("out_row", 72'(bus.out_row), 72'(exp_row));
      chk("out_col", 72'(bus.out_col), 72'(exp_col));
      if (bus.out_valid === 1'b1) begin
        cap_win.push_back(bus.out_win);
        cap_row.push_back(int'(bus.out_row));
        cap_col.push_back(int'(bus.out_col));
        cap_fd.push_back(bus.frame_done);
      end
    end
  end

  // One clock: present the beat, then advance the model to the outputs
  // expected during the following cycle.
  task automatic beat(input bit v, input logic [15:0] d);
    int r;
    int c;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (v) begin
      r = k_m / COLS;
      c = k_m % COLS;
      img_m[r][c] = d[7:0];
      if (r >= 2 && c >= 2) begin
        exp_valid = 1'b1;
        exp_row   = 9'(r - 1);
        exp_col   = 10'(c - 1);
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            exp_win[8*(3*i+j) +: 8] = img_m[r-2+i][c-2+j];
          end
        end
        exp_fd = (k_m == NPIX - 1);
      end
      k_m = (k_m == NPIX - 1) ? 0 : k_m + 1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
  endtask

  task automatic frame(input logic [7:0] base, input bit toggle, input logic [7:0] hi);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        beat(1'b1, {hi, base + 8'(r * 16 + c)});
        if (toggle) beat(1'b0, 16'h0000);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    k_m       = 0;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_win   = '0;
    exp_row   = '0;
    exp_col   = '0;
    #1;
    chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_frame_done", 72'(bus.frame_done), 72'd0);
    chk("rst_out_win", bus.out_win, 72'd0);
    chk("rst_out_row", 72'(bus.out_row), 72'd0);
    chk("rst_out_col", 72'(bus.out_col), 72'd0);
    idle(3);
    rst_n = 1'b1;
  endtask

  task automatic clear_caps();
    cap_win.delete();
    cap_row.delete();
    cap_col.delete();
    cap_fd.delete();
  endtask

  function automatic int diff_vs_ref(input int offset);
    int n = 0;
    for (int w = 0; w < ref_win.size(); w++) begin
      if (w + offset >= cap_win.size()) n++;
      else if (cap_win[w+offset] !== ref_win[w]) n++;
    end
    return n;
  endfunction

  initial begin
    logic [71:0] wv;
    int bad;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    #2;
    cmp_en = 1'b1;
    do_reset();

    // Continuous frame with hand-computed first and last windows.
    frame(8'h00, 1'b0, 8'h00);
    idle(3);
    chk("t1_count", 72'(cap_win.size()), 72'd24);
    if (cap_win.size() == 24) begin
      wv = cap_win[0];
      chk("t1_first_s0", 72'(wv[7:0]), 72'h00);
      chk("t1_first_s4", 72'(wv[39:32]), 72'h11);
      chk("t1_first_s8", 72'(wv[71:64]), 72'h22);
      chk("t1_first_row", 72'(cap_row[0]), 72'd1);
      chk("t1_first_col", 72'(cap_col[0]), 72'd1);
      wv = cap_win[23];
      chk("t1_last_s8", 72'(wv[71:64]), 72'h57);
      chk("t1_last_s0", 72'(wv[7:0]), 72'h35);
      chk("t1_last_row", 72'(cap_row[23]), 72'd4);
      chk("t1_last_col", 72'(cap_col[23]), 72'd6);
      chk("t1_last_fd", 72'(cap_fd[23]), 72'd1);
      chk("t1_mid_fd", 72'(cap_fd[22]), 72'd0);
    end
    ref_win = cap_win;
    clear_caps();

    // in_valid toggling 1-0: same windows.
    frame(8'h00, 1'b1, 8'h00);
    idle(3);
    chk("t2_count", 72'(cap_win.size()), 72'd24);
    chk("t2_same_windows", 72'(diff_vs_ref(0)), 72'd0);
    clear_caps();

    // Two back-to-back frames, the second offset by 0x80.
    frame(8'h00, 1'b0, 8'h00);
    frame(8'h80, 1'b0, 8'h00);
    idle(3);
    chk("t3_count", 72'(cap_win.size()), 72'd48);
    chk("t3_frame1_same", 72'(diff_vs_ref(0)), 72'd0);
    if (cap_win.size() == 48) begin
      wv = cap_win[24];
      chk("t3_f2_first_s0", 72'(wv[7:0]), 72'h80);
      bad = 0;
      for (int w = 24; w < 48; w++) begin
        wv = cap_win[w];
        for (int s = 0; s < 9; s++) begin
          if (wv[8*s +: 8] < 8'h80) bad++;
        end
      end
      chk("t3_f2_no_stale", 72'(bad), 72'd0);
    end
    clear_caps();

    // Reset after pixel (3,4) of a 0x80 frame, then a fresh base-0 frame.
    for (int k = 0; k <= 3 * COLS + 4; k++) begin
      beat(1'b1, {8'h00, 8'h80 + 8'((k / COLS) * 16 + (k % COLS))});
    end
    do_reset();
    clear_caps();
    frame(8'h00, 1'b0, 8'h00);
    idle(3);
    chk("t4_count", 72'(cap_win.size()), 72'd24);
    chk("t4_same_windows", 72'(diff_vs_ref(0)), 72'd0);
    clear_caps();

    // Upper byte of in_data set on every beat must be ignored.
    frame(8'h00, 1'b0, 8'hFF);
    idle(3);
    chk("t5_count", 72'(cap_win.size()), 72'd24);
    chk("t5_same_windows", 72'(diff_vs_ref(0)), 72'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_window_3x3.md
PIXEL_WINDOW_3X3 -- requirements
Module: pixel_window_3x3

Interface
REQ-001 SHALL have parameter COLS, default 640, meaning image width in pixels.
REQ-002 SHALL have parameter ROWS, default 480, meaning image height in pixels.
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  pixel beat qualifier.
REQ-007 SHALL have port in_data  input  16  raster-order pixel in [PIX_W-1:0]; upper bits ignored.
REQ-008 SHALL have port out_valid  output  1  window valid, one-cycle pulse per window.
REQ-009 SHALL have port out_win  output  9*PIX_W  3x3 window; slice [PIX_W*(3*i+j) +: PIX_W] = pixel (cr-1+i, cc-1+j).
REQ-010 SHALL have port out_row  output  9  centre row cr.
REQ-011 SHALL have port out_col  output  10  centre column cc.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of a frame.

Function
REQ-013 SHALL track input position with col counter (0..COLS-1) and row counter (0..ROWS-1), advancing only on in_valid.
REQ-014 SHALL wrap col to 0 and increment row when col=COLS-1; at row=ROWS-1, col=COLS-1 both SHALL wrap to 0.
REQ-015 SHALL tolerate arbitrary in_valid gaps; no state changes when in_valid=0; no backpressure exists.
REQ-016 SHALL keep two line buffers of COLS x PIX_W holding the previous two rows, written at current col on each accepted beat.
REQ-017 SHALL keep a 3x3 shift window fed by {line buffer 2, line buffer 1, in_data} at current col, shifting left on each accepted beat.
REQ-018 SHALL use FSM states FILL (row<2), RUN (row>=2), DONE (one cycle); FILL->RUN at row becoming 2; RUN->DONE on last frame pixel; DONE->FILL unconditionally.
REQ-019 SHALL assert out_valid exactly one cycle after accepting pixel (r,c) with r>=2 and c>=2, with cr=r-1, cc=c-1.
REQ-020 SHALL emit only interior windows: (ROWS-2)*(COLS-2) windows per frame; no border padding.
REQ-021 SHALL hold out_win, out_row, out_col stable when out_valid=0.
REQ-022 SHALL pulse frame_done in DONE, coincident with the final out_valid of the frame.
REQ-023 SHALL accept the first pixel of the next frame in the DONE cycle, treating it as (0,0).
REQ-024 SHALL not use stale line-buffer data across frames: windows of a new frame SHALL contain only that frame's pixels.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear row, col, FSM (to FILL), out_valid, frame_done, out_win, out_row, out_col to 0.
REQ-026 SHALL not require line-buffer RAM contents to reset.
REQ-027 SHALL, on reset mid-frame, discard the partial frame; next accepted pixel is (0,0).

Structure
REQ-028 SHALL place COLS/ROWS defaults, PIX_W and FSM state encodings in shared package sift_pkg.
REQ-029 SHALL instantiate sub-module line_buffer (single-port-read/write, COLS deep, read-before-write) twice.

Verification
REQ-030 SHALL verify COLS=8, ROWS=6, pixel=(r*16+c), continuous in_valid -> 24 windows; first at cr=1,cc=1, out_win slice0=0x00, slice4=0x11, slice8=0x22.
REQ-031 SHALL verify same frame with in_valid toggling 1-0 -> identical 24 windows, each out_valid one cycle after triggering beat.
REQ-032 SHALL verify last pixel (5,7) -> out_valid and frame_done together, cr=4, cc=6, slice8=0x57.
REQ-033 SHALL verify two back-to-back frames, second pixels +0x80 -> 48 windows; second frame first slice0=0x80, no first-frame values.
REQ-034 SHALL verify rst_n low after pixel (3,4) then fresh frame -> all outputs 0 during reset; 24 correct windows afterwards.
REQ-035 SHALL verify in_data upper byte 0xFF on every beat -> out_win identical to REQ-030.
